ips2l_pcie_tx_arb: RTL and testbench
====================================

// Module: ips2l_pcie_tx_arb
// PURPOSE
//  Packet-granular round-robin arbiter sharing one PCIe TX TLP stream among NUM_REQ DMA requesters
//  (e.g. 0=MWr, 1=MRd, 2=CplD). It holds a grant for a whole multi-beat packet and releases it only
//  after the beat carrying last is accepted. It drives the shared TX stream through one registered stage.
// PARAMETERS
//  NUM_REQ     3    number of requesters, 2..8
//  DATA_WIDTH  128  TLP beat width in bits
// PORTS
//  clk        in   1                   single clock, all logic rising-edge
//  rst        in   1                   synchronous, active-high reset
//  req_valid  in   NUM_REQ             per-requester beat valid
//  req_data   in   NUM_REQ*DATA_WIDTH  packed beats, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//  req_last   in   NUM_REQ             per-requester final beat of packet
//  req_ready  out  NUM_REQ             per-requester beat accept, combinational
//  tx_valid   out  1                   registered shared-stream valid
//  tx_data    out  DATA_WIDTH          registered shared-stream beat
//  tx_last    out  1                   registered shared-stream last
//  tx_ready   in   1                   downstream accept
//  grant      out  NUM_REQ             one-hot current owner, registered, 0 when idle
//  busy       out  1                   1 while in XFER
// BEHAVIOUR
//  Reset (rst=1 at an edge): state=IDLE, ptr=0, grant=0, busy=0, tx_valid=0, tx_data=0, tx_last=0.
//   Mid-packet reset abandons the packet. tx_valid reads 0 the cycle after the reset edge, even when
//   the pending beat was never accepted.
//  Handshake: a beat moves when valid&ready are both high at a rising edge. A requester holds valid,
//   data and last stable until accepted. The block does not check this.
//  Output stage: out_free = !tx_valid | tx_ready. On a beat accept from the owner, tx_* load
//   req_*[owner] and tx_valid=1. Else, if tx_ready=1, tx_valid clears to 0. tx_data/tx_last hold.
//  req_ready[i] = (state==XFER) & grant[i] & out_free. It is 0 for all non-owners and in IDLE.
//  FSM:
//   IDLE: if any req_valid, select the first set bit scanning ptr, ptr+1, ... mod NUM_REQ.
//     Register it into grant, busy=1, go to XFER.
//     Arbitration uses req_valid only. It takes exactly 1 cycle, and no beat moves in IDLE.
//   XFER: the owner streams beats at full rate while out_free holds.
//     If the owner drops valid mid-packet, the grant is held and other requesters stay blocked.
//     When the owner's last beat is accepted, go to IDLE on that edge: grant=0, busy=0,
//     ptr=(owner+1) mod NUM_REQ.
//  Latency: req_valid rising in IDLE at cycle 0 gives grant/req_ready in cycle 1 (tx_ready=1 assumed)
//   and the first tx_valid in cycle 2. Back-to-back packets have exactly one bubble cycle between
//   the previous last beat on tx and the next packet's first beat.
//  Fairness: with all requesters continuously valid, grants rotate 0,1,..,NUM_REQ-1,0.
//   A requester waits at most NUM_REQ-1 packets.
//  Single-beat packets (valid&last on the first beat) are legal: one XFER cycle, then IDLE.
//  Simultaneous tx_ready=1 and new owner beat: the new beat replaces the old one in the same edge
//   with no bubble, and tx_valid stays 1.
//  tx_ready=0 stall: tx_* hold and req_ready is 0. Any later beat waits.
//  ptr wraps from NUM_REQ-1 to 0. grant is never multi-hot.
// TESTING
//  1 Reset: assert rst 2 cycles with all req_valid=1 -> tx_valid=0, grant=0, busy=0, req_ready=0.
//    First grant after release goes to req0.
//  2 Single requester: req1 sends a 4-beat packet D0..D3 with tx_ready=1 -> grant=3'b010 at cycle 1.
//    tx carries D0..D3 on cycles 2..5, tx_last only with D3, grant=0 at cycle 6.
//  3 Round robin: all three requesters each stream 2-beat packets continuously ->
//    packet order 0,1,2,0,1,2, with exactly one idle cycle between packets on tx.
//  4 Backpressure: tx_ready=0 for 5 cycles mid-packet -> tx_data holds the same beat and
//    req_ready[owner]=0 throughout. After release, no beat is lost or duplicated.
//  5 Owner gap plus contention: req0 drops valid 3 cycles mid-packet while req2 is valid ->
//    grant stays 3'b001 and req_ready[2]=0 until req0's last beat. Then req2 is granted.
//  6 Reset mid-packet: rst=1 during beat 2 of 4 -> tx_valid=0 next cycle and state=IDLE.
//    After reset, ptr=0 and requester 0 wins first.

Source files
------------

// File: rtl/ips2l_pcie_tx_arb.sv
// Packet-granular round-robin arbiter: one requester owns the shared TX TLP stream
// from grant until its last beat is accepted, through a single registered output stage.
module ips2l_pcie_tx_arb #(
    parameter int NUM_REQ    = 3,
    parameter int DATA_WIDTH = 128
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          tx_valid,
    output logic [DATA_WIDTH-1:0]         tx_data,
    output logic                          tx_last,
    input  logic                          tx_ready,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          busy
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {IDLE, XFER} state_t;

    state_t                 state_reg, state_next;
    logic [PTR_W-1:0]       ptr_reg, ptr_next;
    logic [NUM_REQ-1:0]     grant_reg, grant_next;
    logic                   tx_valid_reg;
    logic [DATA_WIDTH-1:0]  tx_data_reg;
    logic                   tx_last_reg;

    logic                   out_free;
    logic                   beat_acc;
    logic                   owner_last;
    logic [PTR_W-1:0]       owner_idx;
    logic [DATA_WIDTH-1:0]  owner_data;
    logic [DATA_WIDTH-1:0]  masked_data [NUM_REQ];
    logic [PTR_W-1:0]       cand_idx [NUM_REQ];
    logic [NUM_REQ-1:0]     rot_valid;
    logic [PTR_W-1:0]       sel_idx;

    assign out_free   = !tx_valid_reg || tx_ready;
    assign req_ready  = (state_reg == XFER && out_free) ? grant_reg : '0;
    assign beat_acc   = |(req_valid & req_ready);
    assign owner_last = |(req_last & grant_reg);

    // Candidate k of the scan is requester (ptr + k) mod NUM_REQ.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            logic [PTR_W:0] sum;
            assign sum = {1'b0, ptr_reg} + (PTR_W+1)'(gi);
            assign cand_idx[gi]    = (sum >= (PTR_W+1)'(NUM_REQ)) ?
                                     PTR_W'(sum - (PTR_W+1)'(NUM_REQ)) : PTR_W'(sum);
            assign rot_valid[gi]   = req_valid[cand_idx[gi]];
            assign masked_data[gi] = grant_reg[gi] ?
                                     req_data[gi*DATA_WIDTH +: DATA_WIDTH] : '0;
        end
    endgenerate

    // Downward scan so the lowest-offset valid candidate wins.
    always_comb begin
        sel_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot_valid[k]) begin
                sel_idx = cand_idx[k];
            end
        end
    end

    always_comb begin
        owner_data = '0;
        owner_idx  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            owner_data = owner_data | masked_data[i];
            if (grant_reg[i]) begin
                owner_idx = PTR_W'(i);
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        grant_next = grant_reg;
        ptr_next   = ptr_reg;
        case (state_reg)
            IDLE: begin
                if (|req_valid) begin
                    grant_next = {{(NUM_REQ-1){1'b0}}, 1'b1} << sel_idx;
                    state_next = XFER;
                end
            end
            XFER: begin
                if (beat_acc && owner_last) begin
                    state_next = IDLE;
                    grant_next = '0;
                    ptr_next   = (owner_idx == PTR_W'(NUM_REQ - 1)) ? '0 : owner_idx + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                grant_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            ptr_reg   <= '0;
            grant_reg <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            grant_reg <= grant_next;
        end
    end

    // A new owner beat overwrites the stage in the same edge the old one drains.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_valid_reg <= 1'b0;
            tx_data_reg  <= '0;
            tx_last_reg  <= 1'b0;
        end else if (beat_acc) begin
            tx_valid_reg <= 1'b1;
            tx_data_reg  <= owner_data;
            tx_last_reg  <= owner_last;
        end else if (tx_ready) begin
            tx_valid_reg <= 1'b0;
        end
    end

    assign tx_valid = tx_valid_reg;
    assign tx_data  = tx_data_reg;
    assign tx_last  = tx_last_reg;
    assign grant    = grant_reg;
    assign busy     = (state_reg == XFER);

endmodule

// File: tb/tb_ips2l_pcie_tx_arb.sv
// Directed bench for ips2l_pcie_tx_arb: per-requester packet sources, a TX beat log,
// and cycle-exact checks of grant, ready and output-stage behaviour.
module tb_ips2l_pcie_tx_arb;

    localparam int NR = 3;
    localparam int DW = 128;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req_valid;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_last;
    logic [NR-1:0]     req_ready;
    logic              tx_valid;
    logic [DW-1:0]     tx_data;
    logic              tx_last;
    logic              tx_ready;
    logic [NR-1:0]     grant;
    logic              busy;

    ips2l_pcie_tx_arb #(.NUM_REQ(NR), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_last   (tx_last),
        .tx_ready  (tx_ready),
        .grant     (grant),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    int pkt_left [NR];
    int pkt_len  [NR];
    int pkt_idx  [NR];
    int beat_idx [NR];
    bit gap      [NR];

    logic [DW:0] txq [$];
    int first_tx, last_tx, n_tx;

    function automatic logic [DW-1:0] mk(input int i, input int p, input int b);
        logic [DW-1:0] r;
        r          = '0;
        r[127:120] = 8'hA5;
        r[23:0]    = {8'(i), 8'(p), 8'(b)};
        return r;
    endfunction

    task automatic chk(input string tag, input logic [DW:0] obs, input logic [DW:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic setup(input int i, input int n, input int len);
        pkt_left[i] = n;
        pkt_len[i]  = len;
        pkt_idx[i]  = 0;
        beat_idx[i] = 0;
        gap[i]      = 1'b0;
    endtask

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            req_valid[i]             = (pkt_left[i] > 0) && !gap[i];
            req_data[i*DW +: DW]     = mk(i, pkt_idx[i], beat_idx[i]);
            req_last[i]              = (beat_idx[i] == pkt_len[i] - 1);
        end
    endtask

    // Sample handshakes for the current cycle, cross the edge, then present the next cycle.
    task automatic tick();
        logic [NR-1:0] acc;
        acc = req_valid & req_ready;
        if (tx_valid === 1'b1) begin
            if (first_tx < 0) first_tx = cyc;
            last_tx = cyc;
            n_tx++;
            if (tx_ready) txq.push_back({tx_last, tx_data});
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) begin
            if (acc[i] === 1'b1) begin
                if (beat_idx[i] == pkt_len[i] - 1) begin
                    beat_idx[i] = 0;
                    pkt_idx[i]++;
                    pkt_left[i]--;
                end else begin
                    beat_idx[i]++;
                end
            end
        end
        drive();
        #1;
        cyc++;
    endtask

    task automatic run_idle(input string tag);
        int n;
        n = 0;
        while ((pkt_left[0] + pkt_left[1] + pkt_left[2] > 0 || busy !== 1'b0 || tx_valid !== 1'b0)
               && n < 300) begin
            tick();
            n++;
        end
        chk({tag, "_timeout"}, (n >= 300), 0);
    endtask

    task automatic exp_beat(input string tag, input int i, input int p, input int b, input bit l);
        logic [DW:0] e;
        if (txq.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL %s: observed no beat expected %0h", tag, {l, mk(i, p, b)});
        end else begin
            e = txq.pop_front();
            chk(tag, e, {l, mk(i, p, b)});
        end
    endtask

    task automatic new_test();
        txq.delete();
        first_tx = -1;
        last_tx  = -1;
        n_tx     = 0;
        cyc      = 0;
    endtask

    initial begin
        rst      = 1'b1;
        tx_ready = 1'b1;
        for (int i = 0; i < NR; i++) setup(i, 0, 1);
        new_test();

        // 1: reset with all requesters valid
        for (int i = 0; i < NR; i++) setup(i, 1, 1);
        drive();
        #1;
        for (int r = 0; r < 2; r++) begin
            tick();
            chk("rst_tx_valid", tx_valid, 0);
            chk("rst_grant", grant, 0);
            chk("rst_busy", busy, 0);
            chk("rst_req_ready", req_ready, 0);
            chk("rst_tx_data", tx_data, 0);
        end
        rst = 1'b0;
        #1;
        chk("t1_idle_grant", grant, 0);
        chk("t1_idle_ready", req_ready, 0);
        tick();
        chk("t1_first_grant", grant, 3'b001);
        chk("t1_busy", busy, 1);
        chk("t1_ready", req_ready, 3'b001);
        run_idle("t1");
        exp_beat("t1_b0", 0, 0, 0, 1'b1);
        exp_beat("t1_b1", 1, 0, 0, 1'b1);
        exp_beat("t1_b2", 2, 0, 0, 1'b1);
        chk("t1_qempty", txq.size(), 0);

        // 2: single requester, 4-beat packet
        new_test();
        setup(1, 1, 4);
        drive();
        #1;
        chk("t2_c0_grant", grant, 0);
        tick();
        chk("t2_c1_grant", grant, 3'b010);
        chk("t2_c1_ready", req_ready, 3'b010);
        chk("t2_c1_txv", tx_valid, 0);
        tick();
        for (int b = 0; b < 4; b++) begin
            chk($sformatf("t2_txv%0d", b), tx_valid, 1);
            chk($sformatf("t2_txd%0d", b), tx_data, mk(1, 0, b));
            chk($sformatf("t2_txl%0d", b), tx_last, (b == 3));
            if (b == 3) chk("t2_c5_grant", grant, 0);
            tick();
        end
        chk("t2_c6_grant", grant, 0);
        chk("t2_c6_txv", tx_valid, 0);
        chk("t2_c6_busy", busy, 0);

        // 3: round robin, all requesters stream two 2-beat packets each
        rst = 1'b1;
        tick();
        rst = 1'b0;
        new_test();
        for (int i = 0; i < NR; i++) setup(i, 2, 2);
        drive();
        #1;
        run_idle("t3");
        for (int k = 0; k < 6; k++) begin
            exp_beat($sformatf("t3_p%0d_b0", k), k % 3, k / 3, 0, 1'b0);
            exp_beat($sformatf("t3_p%0d_b1", k), k % 3, k / 3, 1, 1'b1);
        end
        chk("t3_first_tx", first_tx, 2);
        chk("t3_span", last_tx - first_tx + 1, 17);
        chk("t3_nvalid", n_tx, 12);

        // 4: backpressure for 5 cycles mid-packet
        new_test();
        setup(0, 1, 4);
        drive();
        #1;
        tick();
        tick();
        tx_ready = 1'b0;
        #1;
        for (int s = 0; s < 5; s++) begin
            chk($sformatf("t4_hold_txd%0d", s), tx_data, mk(0, 0, 0));
            chk($sformatf("t4_hold_txv%0d", s), tx_valid, 1);
            chk($sformatf("t4_hold_rdy%0d", s), req_ready, 0);
            tick();
        end
        tx_ready = 1'b1;
        #1;
        run_idle("t4");
        for (int b = 0; b < 4; b++) exp_beat($sformatf("t4_b%0d", b), 0, 0, b, (b == 3));
        chk("t4_qempty", txq.size(), 0);

        // 5: owner gap with req2 contending
        new_test();
        setup(0, 1, 4);
        drive();
        #1;
        tick();
        chk("t5_c1_grant", grant, 3'b001);
        setup(2, 1, 2);
        drive();
        #1;
        tick();
        tick();
        gap[0] = 1'b1;
        drive();
        #1;
        for (int s = 0; s < 3; s++) begin
            chk($sformatf("t5_gap_grant%0d", s), grant, 3'b001);
            chk($sformatf("t5_gap_rdy2_%0d", s), req_ready[2], 0);
            tick();
        end
        gap[0] = 1'b0;
        drive();
        #1;
        chk("t5_resume_rdy2", req_ready[2], 0);
        run_idle("t5");
        for (int b = 0; b < 4; b++) exp_beat($sformatf("t5_r0_b%0d", b), 0, 0, b, (b == 3));
        exp_beat("t5_r2_b0", 2, 0, 0, 1'b0);
        exp_beat("t5_r2_b1", 2, 0, 1, 1'b1);

        // 6: reset during beat 2 of 4
        new_test();
        setup(1, 1, 4);
        drive();
        #1;
        tick();
        chk("t6_c1_grant", grant, 3'b010);
        tick();
        tick();
        chk("t6_c3_txd", tx_data, mk(1, 0, 1));
        rst = 1'b1;
        setup(0, 1, 1);
        drive();
        #1;
        tick();
        chk("t6_rst_txv", tx_valid, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_grant", grant, 0);
        rst = 1'b0;
        for (int i = 0; i < NR; i++) setup(i, 0, 1);
        setup(0, 1, 1);
        setup(1, 1, 1);
        drive();
        #1;
        txq.delete();
        chk("t6_idle_grant", grant, 0);
        tick();
        chk("t6_first_grant", grant, 3'b001);
        run_idle("t6");
        exp_beat("t6_b0", 0, 0, 0, 1'b1);
        exp_beat("t6_b1", 1, 0, 0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
